// File: rtl/ym3438_bus_writer.sv
// ym3438_bus_writer: host-side initiator for the YM3438 CPU pins.
// Each register write request becomes an address write followed by a data write,
// then the bus is paced before the next request is taken.
// Build option: define YM3438_WR_BUSY_POLL_EN to pace by polling the status busy
// flag (with POLL_MAX reads before giving up) instead of a fixed T_WAIT wait.
module ym3438_bus_writer #(
    parameter int T_SETUP  = 2,
    parameter int T_PULSE  = 4,
    parameter int T_HOLD   = 2,
    parameter int T_GAP    = 16,
    parameter int T_WAIT   = 96,
    parameter int POLL_MAX = 255
) (
    input  logic       MCLK,
    input  logic       IC,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_bank,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       done,
    output logic       timeout,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    output logic [1:0] ADDRESS,
    output logic [7:0] DATA_o,
    output logic       DATA_oe,
    input  logic [7:0] DATA_i
);

    if (T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1 || T_GAP < 1 || T_WAIT < 1 || POLL_MAX < 1) begin : g_param_check
        $error("ym3438_bus_writer: every timing parameter must be >= 1");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SETUP,
        S_A_STROBE,
        S_A_HOLD,
        S_A_GAP,
        S_D_SETUP,
        S_D_STROBE,
        S_D_HOLD,
        S_WAIT,
        S_P_SETUP,
        S_P_STROBE,
        S_P_HOLD,
        S_P_GAP
    } state_t;

    state_t     state, state_next;
    logic [7:0] count, count_next;
    logic       bank_lat, bank_lat_next;
    logic [7:0] addr_lat, addr_lat_next;
    logic [7:0] data_lat, data_lat_next;
    logic       cs_next, wr_next, rd_next, oe_next;
    logic [1:0] address_next;
    logic [7:0] data_o_next;
    logic       done_next, timeout_next, ready_next;

`ifdef YM3438_WR_BUSY_POLL_EN
    logic       busy, busy_next;
    logic [7:0] poll_count, poll_count_next;
`else
    logic       unused_data_i;
    assign unused_data_i = ^DATA_i;
`endif

    // Next-state logic: sequencing, request latch, and the pin values for the state being entered
    always_comb begin
        state_next    = state;
        count_next    = count;
        bank_lat_next = bank_lat;
        addr_lat_next = addr_lat;
        data_lat_next = data_lat;
`ifdef YM3438_WR_BUSY_POLL_EN
        busy_next       = busy;
        poll_count_next = poll_count;
`endif
        if (state != S_IDLE && count != 8'd0) begin
            count_next = count - 8'd1;
        end

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_next    = S_A_SETUP;
                    count_next    = 8'(T_SETUP - 1);
                    bank_lat_next = req_bank;
                    addr_lat_next = req_addr;
                    data_lat_next = req_data;
                end
            end
            S_A_SETUP: if (count == 8'd0) begin state_next = S_A_STROBE; count_next = 8'(T_PULSE - 1); end
            S_A_STROBE: if (count == 8'd0) begin state_next = S_A_HOLD; count_next = 8'(T_HOLD - 1); end
            S_A_HOLD: if (count == 8'd0) begin state_next = S_A_GAP; count_next = 8'(T_GAP - 1); end
            S_A_GAP: if (count == 8'd0) begin state_next = S_D_SETUP; count_next = 8'(T_SETUP - 1); end
            S_D_SETUP: if (count == 8'd0) begin state_next = S_D_STROBE; count_next = 8'(T_PULSE - 1); end
            S_D_STROBE: if (count == 8'd0) begin state_next = S_D_HOLD; count_next = 8'(T_HOLD - 1); end
            S_D_HOLD: begin
                if (count == 8'd0) begin
`ifdef YM3438_WR_BUSY_POLL_EN
                    state_next      = S_P_SETUP;
                    count_next      = 8'(T_SETUP - 1);
                    poll_count_next = 8'd1;
`else
                    state_next = S_WAIT;
                    count_next = 8'(T_WAIT - 1);
`endif
                end
            end
            S_WAIT: if (count == 8'd0) begin state_next = S_IDLE; count_next = 8'd0; end
`ifdef YM3438_WR_BUSY_POLL_EN
            S_P_SETUP: if (count == 8'd0) begin state_next = S_P_STROBE; count_next = 8'(T_PULSE - 1); end
            S_P_STROBE: begin
                if (count == 8'd0) begin
                    state_next = S_P_HOLD;
                    count_next = 8'(T_HOLD - 1);
                    busy_next  = DATA_i[7];
                end
            end
            S_P_HOLD: begin
                if (count == 8'd0) begin
                    if (busy && poll_count < 8'(POLL_MAX)) begin
                        state_next = S_P_GAP;
                        count_next = 8'(T_GAP - 1);
                    end else begin
                        state_next = S_IDLE;
                        count_next = 8'd0;
                    end
                end
            end
            S_P_GAP: begin
                if (count == 8'd0) begin
                    state_next      = S_P_SETUP;
                    count_next      = 8'(T_SETUP - 1);
                    poll_count_next = poll_count + 8'd1;
                end
            end
`endif
            default: begin
                state_next = S_IDLE;
                count_next = 8'd0;
            end
        endcase

        cs_next      = 1'b1;
        wr_next      = 1'b1;
        rd_next      = 1'b1;
        oe_next      = 1'b0;
        address_next = ADDRESS;
        data_o_next  = DATA_o;
        case (state_next)
            S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
                cs_next      = 1'b0;
                oe_next      = 1'b1;
                address_next = {bank_lat_next, 1'b0};
                data_o_next  = addr_lat_next;
                wr_next      = (state_next != S_A_STROBE);
            end
            S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
                cs_next      = 1'b0;
                oe_next      = 1'b1;
                address_next = {bank_lat_next, 1'b1};
                data_o_next  = data_lat_next;
                wr_next      = (state_next != S_D_STROBE);
            end
`ifdef YM3438_WR_BUSY_POLL_EN
            S_P_SETUP, S_P_STROBE, S_P_HOLD: begin
                cs_next      = 1'b0;
                address_next = 2'b00;
                rd_next      = (state_next != S_P_STROBE);
            end
`endif
            default: ;
        endcase

        ready_next = (state_next == S_IDLE);
`ifdef YM3438_WR_BUSY_POLL_EN
        done_next    = (state_next == S_P_HOLD) && (count_next == 8'd0)
                       && (!busy_next || poll_count_next == 8'(POLL_MAX));
        timeout_next = done_next && busy_next;
`else
        done_next    = (state_next == S_WAIT) && (count_next == 8'd0);
        timeout_next = 1'b0;
`endif
    end

    // State register with registered pin outputs; reset aborts any transaction at once
    always_ff @(posedge MCLK or posedge IC) begin
        if (IC) begin
            state     <= S_IDLE;
            count     <= 8'd0;
            bank_lat  <= 1'b0;
            addr_lat  <= 8'd0;
            data_lat  <= 8'd0;
            CS        <= 1'b1;
            WR        <= 1'b1;
            RD        <= 1'b1;
            ADDRESS   <= 2'b00;
            DATA_o    <= 8'd0;
            DATA_oe   <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
`ifdef YM3438_WR_BUSY_POLL_EN
            busy       <= 1'b0;
            poll_count <= 8'd0;
`endif
        end else begin
            state     <= state_next;
            count     <= count_next;
            bank_lat  <= bank_lat_next;
            addr_lat  <= addr_lat_next;
            data_lat  <= data_lat_next;
            CS        <= cs_next;
            WR        <= wr_next;
            RD        <= rd_next;
            ADDRESS   <= address_next;
            DATA_o    <= data_o_next;
            DATA_oe   <= oe_next;
            req_ready <= ready_next;
            done      <= done_next;
            timeout   <= timeout_next;
`ifdef YM3438_WR_BUSY_POLL_EN
            busy       <= busy_next;
            poll_count <= poll_count_next;
`endif
        end
    end

endmodule

// File: tb/tb_ym3438_bus_writer.sv
// tb_ym3438_bus_writer: directed bench for ym3438_bus_writer with hand-computed
// pin timelines. Default build exercises the fixed-wait pacing; building with
// YM3438_WR_BUSY_POLL_EN exercises the busy-poll pacing instead.
module tb_ym3438_bus_writer;

    logic       MCLK = 1'b0;
    logic       IC = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_bank = 1'b0;
    logic [7:0] req_addr = 8'd0;
    logic [7:0] req_data = 8'd0;
    logic       req_ready, done, timeout, CS, WR, RD, DATA_oe;
    logic [1:0] ADDRESS;
    logic [7:0] DATA_o;
    logic [7:0] DATA_i;

    int rd_edges = 0;
    int reads_base = 0;
    int busy_limit = 1000;
    int checks_total = 0;
    int checks_passed = 0;

    int obs_wr_pulses, obs_rd_pulses, obs_rd_bad_addr, obs_rd_bad_oe;
    int obs_wr_len[8];
    int obs_wr_pin[8];
    int obs_wr_data[8];
    int obs_done_cycle[4];
    int obs_done_count, obs_timeout_count, obs_timeout_lone;
    int obs_gap, obs_ready_first, obs_violations;

    // Status byte: busy while fewer than busy_limit reads have finished in this test
    assign DATA_i = {((rd_edges - reads_base) < busy_limit), 7'h15};

    ym3438_bus_writer #(.POLL_MAX(5)) dut (
        .MCLK(MCLK), .IC(IC),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_bank(req_bank), .req_addr(req_addr), .req_data(req_data),
        .done(done), .timeout(timeout),
        .CS(CS), .WR(WR), .RD(RD),
        .ADDRESS(ADDRESS), .DATA_o(DATA_o), .DATA_oe(DATA_oe), .DATA_i(DATA_i)
    );

    // Free-running MCLK, period 10
    always #5 MCLK = ~MCLK;

    // Count finished status reads (RD returning high)
    always @(posedge RD) rd_edges = rd_edges + 1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // Watch the pins for ncycles, sampling each falling edge; cycle 1 is the first after the next rising edge
    task automatic observe(input int ncycles);
        logic prev_wr, prev_rd, prev_cs;
        int   cs_falls, cs_end1;
        obs_wr_pulses = 0; obs_rd_pulses = 0; obs_rd_bad_addr = 0; obs_rd_bad_oe = 0;
        obs_done_count = 0; obs_timeout_count = 0; obs_timeout_lone = 0;
        obs_gap = -1; obs_ready_first = 0; obs_violations = 0;
        foreach (obs_wr_len[i]) begin obs_wr_len[i] = 0; obs_wr_pin[i] = -1; obs_wr_data[i] = -1; end
        foreach (obs_done_cycle[i]) obs_done_cycle[i] = -1;
        prev_wr = 1'b1; prev_rd = 1'b1; prev_cs = 1'b1; cs_falls = 0; cs_end1 = 0;
        for (int k = 1; k <= ncycles; k++) begin
            @(negedge MCLK);
            if (!WR) begin
                if (prev_wr) begin
                    if (obs_wr_pulses < 8) begin
                        obs_wr_pin[obs_wr_pulses] = int'(ADDRESS);
                        obs_wr_data[obs_wr_pulses] = int'(DATA_o);
                    end
                    obs_wr_pulses++;
                end
                if (obs_wr_pulses <= 8) obs_wr_len[obs_wr_pulses - 1]++;
            end
            if (!RD) begin
                if (prev_rd) obs_rd_pulses++;
                if (ADDRESS != 2'b00) obs_rd_bad_addr++;
                if (DATA_oe) obs_rd_bad_oe++;
            end
            if (!CS && prev_cs) begin
                cs_falls++;
                if (cs_falls == 2) obs_gap = k - cs_end1;
            end
            if (CS && !prev_cs && cs_falls == 1) cs_end1 = k;
            if (done) begin
                if (obs_done_count < 4) obs_done_cycle[obs_done_count] = k;
                obs_done_count++;
            end
            if (timeout) begin
                obs_timeout_count++;
                if (!done) obs_timeout_lone++;
            end
            if (req_ready && obs_ready_first == 0) obs_ready_first = k;
            if ((!WR && !RD) || ((!WR || !RD) && CS) || (!RD && DATA_oe)) obs_violations++;
            prev_wr = WR; prev_rd = RD; prev_cs = CS;
        end
    endtask

    // Present one request from an idle bus, drop valid after acceptance, and watch the pins
    task automatic applyStimulus(input logic bank, input logic [7:0] addr, input logic [7:0] data,
                                 input int ncycles);
        req_bank = bank; req_addr = addr; req_data = data; req_valid = 1'b1;
        fork
            begin @(posedge MCLK); #1 req_valid = 1'b0; end
            observe(ncycles);
        join
    endtask

    // Keep req_valid high across three queued requests, switching payload after each acceptance
    task automatic driveQueue();
        logic       banks[3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] addrs[3] = '{8'h30, 8'hB4, 8'h28};
        logic [7:0] datas[3] = '{8'h71, 8'hC0, 8'hF1};
        int waited;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge MCLK);
            req_bank = banks[i]; req_addr = addrs[i]; req_data = datas[i]; req_valid = 1'b1;
            waited = 0;
            while (!req_ready && waited < 300) begin @(negedge MCLK); waited++; end
            checkOutput("queue_ready_seen", int'(req_ready), 1);
            @(posedge MCLK);
        end
        @(negedge MCLK);
        req_valid = 1'b0;
    endtask

    initial begin
        #3 IC = 1'b1;
        repeat (2) @(negedge MCLK);
        checkOutput("rst_cs", int'(CS), 1);
        checkOutput("rst_wr", int'(WR), 1);
        checkOutput("rst_rd", int'(RD), 1);
        checkOutput("rst_address", int'(ADDRESS), 0);
        checkOutput("rst_data_o", int'(DATA_o), 0);
        checkOutput("rst_data_oe", int'(DATA_oe), 0);
        checkOutput("rst_ready", int'(req_ready), 1);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_timeout", int'(timeout), 0);
        IC = 1'b0;

`ifdef YM3438_WR_BUSY_POLL_EN
        // Busy for three reads, then free: 4 reads, done at end of 4th read's hold
        busy_limit = 3; reads_base = rd_edges;
        applyStimulus(1'b0, 8'h28, 8'hF0, 160);
        checkOutput("p1_wr_pulses", obs_wr_pulses, 2);
        checkOutput("p1_rd_pulses", obs_rd_pulses, 4);
        checkOutput("p1_rd_addr_bad", obs_rd_bad_addr, 0);
        checkOutput("p1_rd_oe_bad", obs_rd_bad_oe, 0);
        checkOutput("p1_done_count", obs_done_count, 1);
        checkOutput("p1_done_cycle", obs_done_cycle[0], 112);
        checkOutput("p1_timeout", obs_timeout_count, 0);
        checkOutput("p1_ready_first", obs_ready_first, 113);
        checkOutput("p1_rules", obs_violations, 0);

        // Busy forever with POLL_MAX = 5: five reads, then done and timeout together
        busy_limit = 1000; reads_base = rd_edges;
        applyStimulus(1'b1, 8'hA4, 8'h22, 180);
        checkOutput("p2_rd_pulses", obs_rd_pulses, 5);
        checkOutput("p2_done_count", obs_done_count, 1);
        checkOutput("p2_done_cycle", obs_done_cycle[0], 136);
        checkOutput("p2_timeout_count", obs_timeout_count, 1);
        checkOutput("p2_timeout_alone", obs_timeout_lone, 0);
        checkOutput("p2_rules", obs_violations, 0);
`else
        // Bank 0, reg 0x28, value 0xF0: address then data pulse, 16 gap, done at 128
        applyStimulus(1'b0, 8'h28, 8'hF0, 132);
        checkOutput("t1_wr_pulses", obs_wr_pulses, 2);
        checkOutput("t1_a_len", obs_wr_len[0], 4);
        checkOutput("t1_a_pin", obs_wr_pin[0], 0);
        checkOutput("t1_a_data", obs_wr_data[0], 'h28);
        checkOutput("t1_d_len", obs_wr_len[1], 4);
        checkOutput("t1_d_pin", obs_wr_pin[1], 1);
        checkOutput("t1_d_data", obs_wr_data[1], 'hF0);
        checkOutput("t1_cs_gap", obs_gap, 16);
        checkOutput("t1_done_count", obs_done_count, 1);
        checkOutput("t1_done_cycle", obs_done_cycle[0], 128);
        checkOutput("t1_ready_first", obs_ready_first, 129);
        checkOutput("t1_timeout", obs_timeout_count, 0);
        checkOutput("t1_rd_pulses", obs_rd_pulses, 0);
        checkOutput("t1_rules", obs_violations, 0);

        // Bank 1 uses pin addresses 2 then 3
        applyStimulus(1'b1, 8'hA4, 8'h22, 132);
        checkOutput("t2_a_pin", obs_wr_pin[0], 2);
        checkOutput("t2_a_data", obs_wr_data[0], 'hA4);
        checkOutput("t2_d_pin", obs_wr_pin[1], 3);
        checkOutput("t2_d_data", obs_wr_data[1], 'h22);
        checkOutput("t2_done_cycle", obs_done_cycle[0], 128);
        checkOutput("t2_ready_first", obs_ready_first, 129);

        // Three queued requests, one IDLE cycle between transactions
        fork
            driveQueue();
            observe(392);
        join
        checkOutput("t3_wr_pulses", obs_wr_pulses, 6);
        checkOutput("t3_data0", obs_wr_data[0], 'h30);
        checkOutput("t3_data1", obs_wr_data[1], 'h71);
        checkOutput("t3_pin2", obs_wr_pin[2], 2);
        checkOutput("t3_data2", obs_wr_data[2], 'hB4);
        checkOutput("t3_data3", obs_wr_data[3], 'hC0);
        checkOutput("t3_data4", obs_wr_data[4], 'h28);
        checkOutput("t3_data5", obs_wr_data[5], 'hF1);
        checkOutput("t3_done_count", obs_done_count, 3);
        checkOutput("t3_done0", obs_done_cycle[0], 128);
        checkOutput("t3_done1", obs_done_cycle[1], 257);
        checkOutput("t3_done2", obs_done_cycle[2], 386);
        checkOutput("t3_rules", obs_violations, 0);

        // Reset during the data strobe aborts at once
        req_bank = 1'b0; req_addr = 8'h2B; req_data = 8'h80; req_valid = 1'b1;
        fork
            begin @(posedge MCLK); #1 req_valid = 1'b0; end
            repeat (28) @(negedge MCLK);
        join
        checkOutput("t4_pre_wr", int'(WR), 0);
        #2 IC = 1'b1;
        #1;
        checkOutput("t4_cs", int'(CS), 1);
        checkOutput("t4_wr", int'(WR), 1);
        checkOutput("t4_oe", int'(DATA_oe), 0);
        checkOutput("t4_ready", int'(req_ready), 1);
        checkOutput("t4_done", int'(done), 0);
        @(negedge MCLK);
        IC = 1'b0;
        observe(140);
        checkOutput("t4_no_done", obs_done_count, 0);
        checkOutput("t4_no_wr", obs_wr_pulses, 0);
        applyStimulus(1'b0, 8'h2B, 8'h80, 132);
        checkOutput("t4_after_pulses", obs_wr_pulses, 2);
        checkOutput("t4_after_data", obs_wr_data[1], 'h80);
        checkOutput("t4_after_done", obs_done_cycle[0], 128);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
